// File: rtl/uart_packet_parser.sv
// uart_packet_parser: assembles SYNC/LEN/payload/checksum frames from the
// UART receive byte stream into a payload buffer. A validated packet is
// held for the command layer until it is acknowledged. Length, checksum,
// inter-byte timeout and overrun conditions are reported as single-cycle
// error pulses.
module uart_packet_parser #(
  parameter int          MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
  parameter int          TIMEOUT_TICKS = 1000,
  parameter int          AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [7:0]    data_in,
  input  logic          data_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          pkt_valid,
  output logic [7:0]    pkt_len,
  input  logic          pkt_ack,
  output logic          busy,
  output logic          len_err,
  output logic          crc_err,
  output logic          timeout_err,
  output logic          ovr_err
);

  // The buffer is rounded up to a power of two so every rd_addr value is
  // a legal index; entries at or above MAX_LEN are simply never written.
  localparam int          DEPTH     = 1 << AW;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DONE} state_t;

  state_t      state;
  logic [7:0]  len_reg;
  logic [7:0]  idx;
  logic [7:0]  csum;
  logic [15:0] to_cnt;
  logic        in_frame;
  logic        to_hit;
  logic [7:0]  mem [DEPTH];

  // Additive checksum: 8-bit wrap, carry discarded.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // A byte arriving together with the threshold tick takes priority.
  assign to_hit   = in_frame && tick && !data_ready && (to_cnt == TO_LAST);
  assign rd_data  = mem[rd_addr];

  // Inter-byte timeout counter: counts ticks only while inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_frame || data_ready || to_hit) begin
      to_cnt <= '0;
    end else if (tick) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Payload storage; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && data_ready) begin
      mem[idx[AW-1:0]] <= data_in;
    end
  end

  // Frame FSM with registered status outputs and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_reg     <= '0;
      idx         <= '0;
      csum        <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      ovr_err     <= 1'b0;
    end else begin
      len_err     <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      ovr_err     <= 1'b0;
      if (to_hit) begin
        timeout_err <= 1'b1;
        state       <= IDLE;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (data_ready && data_in == SYNC_BYTE) begin
              state <= LEN;
              busy  <= 1'b1;
            end
          end
          LEN: begin
            if (data_ready) begin
              if (data_in == 8'd0 || data_in > MAX_LEN_B) begin
                len_err <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
              end else begin
                len_reg <= data_in;
                csum    <= data_in;
                idx     <= '0;
                state   <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (data_ready) begin
              csum <= csum_add(csum, data_in);
              idx  <= idx + 8'd1;
              if (idx == len_reg - 8'd1) begin
                state <= CHK;
              end
            end
          end
          CHK: begin
            if (data_ready) begin
              busy <= 1'b0;
              if (data_in == csum) begin
                state     <= DONE;
                pkt_valid <= 1'b1;
                pkt_len   <= len_reg;
              end else begin
                crc_err <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          DONE: begin
            ovr_err <= data_ready;
            if (pkt_ack) begin
              state     <= IDLE;
              pkt_valid <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// tb_uart_packet_parser: directed frames plus randomized frames whose
// expected outcome (held payload, length, or error kind) is fixed when the
// frame is built; the checksum is computed here as a plain byte sum.
module tb_uart_packet_parser;

  localparam int MAX_LEN = 16;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [7:0]    data_in;
  logic          data_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          pkt_valid;
  logic [7:0]    pkt_len;
  logic          pkt_ack;
  logic          busy;
  logic          len_err;
  logic          crc_err;
  logic          timeout_err;
  logic          ovr_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_pl[$];

  uart_packet_parser #(
    .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(8'hAA),
    .TIMEOUT_TICKS(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .data_in(data_in),
    .data_ready(data_ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pkt_valid(pkt_valid),
    .pkt_len(pkt_len),
    .pkt_ack(pkt_ack),
    .busy(busy),
    .len_err(len_err),
    .crc_err(crc_err),
    .timeout_err(timeout_err),
    .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    cyc();
    pkt_ack = 1'b0;
  endtask

  function automatic logic [7:0] frame_sum();
    logic [7:0] s;
    s = 8'(exp_pl.size());
    foreach (exp_pl[i]) s = s + exp_pl[i];
    return s;
  endfunction

  function automatic logic [7:0] non_sync();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hAA) b = 8'h00;
    return b;
  endfunction

  task automatic check_errs(input string tag, input logic l, input logic c,
                            input logic t, input logic o);
    chk({tag, "_len_err"}, len_err, l);
    chk({tag, "_crc_err"}, crc_err, c);
    chk({tag, "_timeout_err"}, timeout_err, t);
    chk({tag, "_ovr_err"}, ovr_err, o);
  endtask

  // Compare the held packet against the expected payload.
  task automatic check_held(input string tag);
    chk({tag, "_pkt_valid"}, pkt_valid, 1'b1);
    chk({tag, "_pkt_len"}, pkt_len, exp_pl.size());
    chk({tag, "_busy"}, busy, 1'b0);
    check_errs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (exp_pl[i]) begin
      rd_addr = AW'(i);
      #1;
      chk({tag, "_rd_data"}, rd_data, exp_pl[i]);
    end
    cyc();
  endtask

  // Load exp_pl with a random payload and queue its full frame.
  task automatic build_frame(input int len, input logic [7:0] crc_delta);
    exp_pl.delete();
    for (int i = 0; i < len; i++) exp_pl.push_back(8'($urandom_range(0, 255)));
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'(len));
    foreach (exp_pl[i]) tx_q.push_back(exp_pl[i]);
    tx_q.push_back(frame_sum() + crc_delta);
  endtask

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    data_in    = 8'h00;
    data_ready = 1'b0;
    rd_addr    = '0;
    pkt_ack    = 1'b0;
    repeat (3) cyc();
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_len", pkt_len, 8'h00);
    chk("rst_busy", busy, 1'b0);
    check_errs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();

    // Good frame
    send_byte(8'hAA);
    chk("good_busy_after_sync", busy, 1'b1);
    tx_q = '{8'h03, 8'h11, 8'h22, 8'h33};
    send_q();
    chk("good_no_valid_before_chk", pkt_valid, 1'b0);
    send_byte(8'h69);
    exp_pl = '{8'h11, 8'h22, 8'h33};
    check_held("good");
    ack();
    chk("good_ack_valid", pkt_valid, 1'b0);
    chk("good_ack_len_hold", pkt_len, 8'h03);

    // Bad checksum, then a good single-byte frame
    tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_q();
    check_errs("badcrc", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("badcrc_valid", pkt_valid, 1'b0);
    chk("badcrc_busy", busy, 1'b0);
    cyc();
    chk("badcrc_single_pulse", crc_err, 1'b0);
    tx_q = '{8'hAA, 8'h01, 8'h55, 8'h56};
    send_q();
    exp_pl = '{8'h55};
    check_held("after_badcrc");
    ack();

    // Length errors
    tx_q = '{8'hAA, 8'h00};
    send_q();
    check_errs("len0", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("len0_busy", busy, 1'b0);
    tx_q = '{8'hAA, 8'h11};
    send_q();
    check_errs("len17", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("len17_busy", busy, 1'b0);

    // Timeout
    tx_q = '{8'hAA, 8'h02, 8'h11};
    send_q();
    ticks(999);
    chk("to_999_err", timeout_err, 1'b0);
    chk("to_999_busy", busy, 1'b1);
    ticks(1);
    chk("to_1000_err", timeout_err, 1'b1);
    chk("to_1000_busy", busy, 1'b0);
    send_byte(8'hAA);
    ticks(999);
    send_byte(8'h01);
    ticks(999);
    send_byte(8'h7F);
    ticks(999);
    send_byte(8'h80);
    exp_pl = '{8'h7F};
    check_held("to_slow");
    ack();

    // Garbage then overrun
    send_byte(8'h00);
    chk("garbage_busy", busy, 1'b0);
    tx_q = '{8'hFF, 8'hAA, 8'h01, 8'h7F, 8'h80};
    send_q();
    exp_pl = '{8'h7F};
    check_held("garbage");
    send_byte(8'h12);
    chk("ovr1", ovr_err, 1'b1);
    send_byte(8'h34);
    chk("ovr2", ovr_err, 1'b1);
    chk("ovr_valid_held", pkt_valid, 1'b1);
    rd_addr = '0;
    #1;
    chk("ovr_buf_frozen", rd_data, 8'h7F);
    cyc();
    chk("ovr_pulse_end", ovr_err, 1'b0);
    pkt_ack = 1'b1;
    send_byte(8'h56);
    pkt_ack = 1'b0;
    chk("ackdata_ovr", ovr_err, 1'b1);
    chk("ackdata_valid", pkt_valid, 1'b0);
    chk("ackdata_busy", busy, 1'b0);
    pkt_ack = 1'b1;
    send_byte(8'hAA);
    pkt_ack = 1'b0;
    chk("ack_ignored_busy", busy, 1'b1);
    send_byte(8'h00);
    chk("ack_ignored_len_err", len_err, 1'b1);

    // Reset mid-payload
    tx_q = '{8'hAA, 8'h01, 8'h09, 8'h0A};
    send_q();
    chk("pre_rst_len", pkt_len, 8'h01);
    ack();
    tx_q = '{8'hAA, 8'h04, 8'h01, 8'h02};
    send_q();
    chk("pre_rst_busy", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_valid", pkt_valid, 1'b0);
    chk("async_rst_len", pkt_len, 8'h00);
    check_errs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    tx_q = '{8'hAA, 8'h01, 8'h05, 8'h06};
    send_q();
    exp_pl = '{8'h05};
    check_held("post_rst");
    ack();

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 3));
      if (kind == 0 || kind == 3) begin
        if (kind == 3) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) tx_q.push_back(non_sync());
        end
        len = int'($urandom_range(1, MAX_LEN));
        build_frame(len, 8'h00);
        send_q();
        check_held("rnd_good");
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          send_byte(non_sync());
          chk("rnd_ovr", ovr_err, 1'b1);
        end
        begin
          int a;
          a = int'($urandom_range(0, len - 1));
          rd_addr = AW'(a);
          #1;
          chk("rnd_frozen", rd_data, exp_pl[a]);
          cyc();
        end
        ack();
        chk("rnd_ack_valid", pkt_valid, 1'b0);
      end else if (kind == 1) begin
        len = int'($urandom_range(1, MAX_LEN));
        build_frame(len, 8'($urandom_range(1, 255)));
        send_q();
        check_errs("rnd_badcrc", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rnd_badcrc_valid", pkt_valid, 1'b0);
        chk("rnd_badcrc_busy", busy, 1'b0);
      end else begin
        tx_q.push_back(8'hAA);
        tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        send_q();
        check_errs("rnd_badlen", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rnd_badlen_busy", busy, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Sits directly downstream of the UART echo top level. Consumes the received byte stream (data_out / data_ready) and assembles framed packets into an internal payload buffer.
- Frame format: SYNC byte, LEN byte, LEN payload bytes, 8-bit additive checksum.
- Presents a validated packet to the command layer through a random-access read port and a valid/ack handshake.
- Flags length, checksum, inter-byte timeout and overrun errors.

Parameters:
- MAX_LEN, 16: maximum payload bytes. Legal range 1..255.
- SYNC_BYTE, 8'hAA: frame start marker.
- TIMEOUT_TICKS, 1000: number of tick pulses allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  baud tick pulse; the same pulse that drives the UART
- data_in  in  8  received byte; valid only when data_ready=1
- data_ready  in  1  one-cycle pulse per received byte
- rd_addr  in  AW  payload read index, AW=$clog2(MAX_LEN)
- rd_data  out  8  buffer[rd_addr], combinational
- pkt_valid  out  1  complete, checksum-correct packet is held in the buffer
- pkt_len  out  8  payload length of the held packet
- pkt_ack  in  1  consumer releases the packet
- busy  out  1  FSM is in LEN, PAYLOAD or CHK
- len_err  out  1  one-cycle pulse
- crc_err  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse
- ovr_err  out  1  one-cycle pulse

Behaviour:
- Reset (async, active-high): state=IDLE. pkt_valid, pkt_len, busy, all *_err, byte index, checksum and timeout counter all =0. Buffer contents are not reset.
- A byte is consumed only in a cycle where data_ready=1. All state updates and error pulses are registered: they appear the cycle after that data_ready.
- FSM states: IDLE, LEN, PAYLOAD, CHK, DONE.
- IDLE:
  - data_in==SYNC_BYTE -> LEN.
  - Any other byte is discarded silently.
- LEN:
  - data_in==0 or data_in>MAX_LEN -> pulse len_err, go to IDLE.
  - Otherwise: len_reg=data_in, checksum=data_in, idx=0, go to PAYLOAD.
  - A SYNC_BYTE value here is treated as a length, not as a resync.
- PAYLOAD:
  - On each byte: buffer[idx]=data_in, checksum=(checksum+data_in) mod 256, idx++.
  - After the byte with idx==len_reg-1 is written -> CHK.
- CHK:
  - data_in==checksum -> DONE; pkt_valid=1 and pkt_len=len_reg on the next edge. Latency is 1 cycle after the checksum byte's data_ready.
  - Mismatch -> pulse crc_err, go to IDLE, pkt_valid stays 0.
- DONE:
  - pkt_valid held high.
  - Buffer frozen; any data_ready is dropped and pulses ovr_err.
  - pkt_ack=1 -> IDLE, pkt_valid=0 next cycle, pkt_len holds its last value.
  - pkt_ack is ignored outside DONE.
  - If pkt_ack and data_ready arrive in the same cycle: ack wins, the byte is dropped, ovr_err pulses.
- Timeout:
  - In LEN, PAYLOAD and CHK a 16-bit counter increments on each tick and clears on each data_ready.
  - Counter reaching TIMEOUT_TICKS -> pulse timeout_err, go to IDLE, counter cleared.
  - If data_ready and the threshold tick coincide, the byte wins and no timeout occurs.
  - The counter is held at 0 in IDLE and DONE.
- busy=1 exactly in LEN, PAYLOAD and CHK.
- rd_data is combinational from the buffer at all times. It is only meaningful while pkt_valid=1 and rd_addr<pkt_len; outside that it returns stale contents.
- Reset mid-frame: immediate return to IDLE, no error pulse, pkt_valid=0.
- Checksum arithmetic is 8-bit and wraps; no carry is kept.

Test Plan:
- Good frame: bytes AA 03 11 22 33 69 -> pkt_valid=1 one cycle after 69, pkt_len=3, rd_addr 0/1/2 -> 11/22/33, no error pulses. Assert pkt_ack -> pkt_valid=0 the next cycle.
- Bad checksum: AA 03 11 22 33 6A -> crc_err single pulse, pkt_valid stays 0. Follow with AA 01 55 56 -> valid packet, pkt_len=1, rd_data[0]=55.
- Length checks: AA 00 -> len_err. AA 11 (17 > MAX_LEN=16) -> len_err. Both return to IDLE, busy=0.
- Timeout: AA 02 11, then 1000 ticks with no byte -> timeout_err pulse, busy=0. Next, 999 ticks between bytes of AA 01 7F 80 -> no timeout, packet accepted.
- Garbage and overrun: 00 FF AA 01 7F 80 -> valid with rd_data[0]=7F. While pkt_valid is held, send 12 34 -> two ovr_err pulses, rd_data[0] still 7F.
- Reset mid-PAYLOAD after AA 04 01 02: assert rst -> all outputs 0 asynchronously. Then AA 01 05 06 -> valid packet, pkt_len=1.
